// File: rtl/ahb_mem_slave.sv
// AHB-Lite slave memory: registered read path with write-to-read forwarding,
// WAIT_STATES stall cycles, two-cycle ERROR. Optional mailbox: `AHB_MEM_MAILBOX_EN.
module ahb_mem_slave #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned DEPTH        = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned WAIT_STATES  = 0,
    parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
`ifdef AHB_MEM_MAILBOX_EN
    ,
    output logic              mailbox_wr,
    output logic [7:0]        mailbox_data
`endif
);

    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned OFF_W     = $clog2(BYTES);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAST,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              mbox_q, mbox_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [31:0]       rel_addr;
    logic [IDX_W-1:0]  a_idx;
    logic [OFF_W-1:0]  a_off;
    logic              in_range, size_ok, aligned, mbox_hit, legal;
    logic              can_accept, accept;
    logic              commit;
    logic [BYTES-1:0]  commit_strb;
    logic [IDX_W-1:0]  rd_idx;
    logic              enter_last, rd_zero;
    logic              unused_ok;

    function automatic logic [BYTES-1:0] strobes(input logic [OFF_W-1:0] off,
                                                  input logic [2:0]       size);
        logic [BYTES-1:0] s;
        s = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            s[b] = (b >= 32'(off)) && (b < 32'(off) + (32'd1 << size));
        end
        return s;
    endfunction

    always_comb begin
        rel_addr   = HADDR - BASE_ADDR;
        a_idx      = rel_addr[OFF_W +: IDX_W];
        a_off      = rel_addr[OFF_W-1:0];
        // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both ends
        in_range   = rel_addr < MEM_BYTES;
        size_ok    = 32'(HSIZE) <= OFF_W;
        aligned    = (HADDR & ((32'd1 << HSIZE) - 32'd1)) == '0;
`ifdef AHB_MEM_MAILBOX_EN
        mbox_hit   = (HADDR == MAILBOX_ADDR) && size_ok;
`else
        mbox_hit   = 1'b0;
`endif
        legal      = (in_range && size_ok && aligned) || mbox_hit;
        can_accept = (state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2);
        accept     = HSEL && HTRANS[1] && HREADY && can_accept;
    end

    always_comb begin
        commit      = (state_q == S_LAST) && write_q && !mbox_q && !HRESET;
        commit_strb = strobes(off_q, size_q);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        off_d      = off_q;
        size_d     = size_q;
        write_d    = write_q;
        mbox_d     = mbox_q;
        hrdata_d   = hrdata_q;
        rd_idx     = idx_q;
        enter_last = 1'b0;
        rd_zero    = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d    = S_LAST;
                    enter_last = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = a_idx;
                    off_d   = a_off;
                    size_d  = HSIZE;
                    write_d = HWRITE;
                    mbox_d  = mbox_hit;
                    rd_idx  = a_idx;
                    if (!legal) begin
                        state_d = S_ERR1;
                        rd_zero = !HWRITE;
                    end else if (WAIT_STATES == 0) begin
                        state_d    = S_LAST;
                        enter_last = 1'b1;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = 3'(WAIT_STATES - 1);
                    end
                end
            end
        endcase

        // A write committing on this same edge is merged into the read word
        if (rd_zero) begin
            hrdata_d = '0;
        end else if (enter_last && !write_d) begin
            if (mbox_d) begin
                hrdata_d = '0;
            end else begin
                hrdata_d = mem[rd_idx];
                if (commit && (idx_q == rd_idx)) begin
                    for (int unsigned b = 0; b < BYTES; b++) begin
                        if (commit_strb[b]) hrdata_d[8*b +: 8] = HWDATA[8*b +: 8];
                    end
                end
            end
        end

        hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
        hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            idx_q       <= '0;
            off_q       <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            mbox_q      <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            idx_q       <= idx_d;
            off_q       <= off_d;
            size_q      <= size_d;
            write_q     <= write_d;
            mbox_q      <= mbox_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (commit_strb[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        HREADYOUT = hreadyout_q;
        HRESP     = hresp_q;
        HRDATA    = hrdata_q;
    end

`ifdef AHB_MEM_MAILBOX_EN
    logic       mailbox_wr_q, mailbox_wr_d;
    logic [7:0] mailbox_data_q, mailbox_data_d;

    always_comb begin
        mailbox_wr_d   = (state_q == S_LAST) && write_q && mbox_q;
        mailbox_data_d = mailbox_wr_d ? HWDATA[8*off_q +: 8] : mailbox_data_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mailbox_wr_q   <= 1'b0;
            mailbox_data_q <= '0;
        end else begin
            mailbox_wr_q   <= mailbox_wr_d;
            mailbox_data_q <= mailbox_data_d;
        end
    end

    always_comb begin
        mailbox_wr   = mailbox_wr_q;
        mailbox_data = mailbox_data_q;
    end

    always_comb unused_ok = ^{HTRANS[0], HBURST, HPROT};
`else
    always_comb unused_ok = ^{HTRANS[0], HBURST, HPROT, MAILBOX_ADDR};
`endif

endmodule

// File: doc/ahb_mem_slave.md
# ahb_mem_slave

Parametrised AHB-Lite slave memory model for the SweRV testbench: a byte-addressable word array with a configurable data bus width, depth and number of wait states. It accepts pipelined AHB-Lite transfers from a core bus port (LSU, IFU or DMA), drives a fully registered read path with write-to-read forwarding, and returns two-cycle ERROR responses for illegal accesses. An optional mailbox decode captures testbench console and exit writes.

## Interface
Parameters:
- DATA_W, 64: bus data width; 32 or 64.
- DEPTH, 4096: number of DATA_W-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to the array size.
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase; range 0..7.
- MAILBOX_ADDR, 32'hD058_0000: mailbox byte address; used only with the mailbox feature.

Ports:
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; only NONSEQ and SEQ (HTRANS[1]=1) are transfers.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  ignored; every beat is decoded on its own.
- HPROT  in  4  ignored.
- HWDATA  in  DATA_W  write data, valid in the data phase.
- HREADY  in  1  bus ready; qualifies address-phase acceptance.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_W  read data; registered.
- mailbox_wr  out  1  one-cycle pulse on a mailbox write (only with AHB_MEM_MAILBOX_EN).
- mailbox_data  out  8  byte written to the mailbox (only with AHB_MEM_MAILBOX_EN).

## Operation
- Address phase accept: HSEL & HTRANS[1] & HREADY. On accept, capture the word index, byte offset, HSIZE and HWRITE.
- Legal access, all three conditions true:
  - HADDR is in [BASE_ADDR, BASE_ADDR + DEPTH*DATA_W/8).
  - 2^HSIZE ≤ DATA_W/8.
  - HADDR is aligned to 2^HSIZE.
- Byte strobes: ((1<<2^HSIZE)-1) << HADDR[log2(DATA_W/8)-1:0]. Lanes are little-endian.
- States: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
  - Accept, legal, WAIT_STATES=0 → LAST.
  - Accept, legal, WAIT_STATES>0 → WAIT with the counter loaded to WAIT_STATES-1.
  - Accept, illegal → ERR1.
  - WAIT: HREADYOUT=0. The counter decrements each cycle. At counter 0 → LAST.
  - LAST: HREADYOUT=1, HRESP=0; the data phase completes this cycle. If a new transfer is accepted in the same cycle, go to its next state (back-to-back); otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always → ERR2. No address is accepted here because HREADY is low.
  - ERR2: HREADYOUT=1, HRESP=1. Same next-state rules as LAST.
- Writes: strobed bytes of HWDATA are committed to the memory array on the LAST edge. Illegal writes never modify memory.
- Reads:
  - HRDATA is loaded on the edge that enters LAST.
  - With WAIT_STATES=0 that edge falls in the address-phase cycle. If a write to the same word is committing on that same edge, its strobed bytes are forwarded into HRDATA.
  - Illegal reads load HRDATA = 0.
- Memory contents are not reset and start as X unless preloaded by the bench.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0, mailbox_wr=0, mailbox_data=0.
- OKAY transfer latency: the data phase lasts WAIT_STATES+1 cycles.
- ERROR response: always 2 data-phase cycles, independent of WAIT_STATES.
- Back-to-back transfers at 100% throughput when WAIT_STATES=0.
- Read after write to the same word, consecutive beats: the read returns the newly written bytes, merged per strobe.
- Reset mid-transfer (WAIT, ERR1 or LAST state): the transfer is aborted, no memory write occurs, and all outputs return to their reset values on the next edge.
- HTRANS IDLE or BUSY, or HSEL=0: no state change; zero-wait OKAY.

## Configuration
- AHB_MEM_MAILBOX_EN defined:
  - A legal-size write to MAILBOX_ADDR returns OKAY with WAIT_STATES applied.
  - The memory is not written.
  - mailbox_wr pulses high for the cycle after LAST.
  - mailbox_data holds the addressed byte lane of HWDATA and stays valid until the next mailbox write.
  - Reads of MAILBOX_ADDR return 0, OKAY.
- AHB_MEM_MAILBOX_EN undefined:
  - The mailbox_wr and mailbox_data ports are absent.
  - MAILBOX_ADDR is decoded like any other address: out of range → ERROR.

## Test plan
- Reset, DATA_W=64, WAIT_STATES=0 → HREADYOUT=1, HRESP=0, HRDATA=0 on the first cycle after HRESET falls.
- Byte write 8'hA5 to 0x5, then 64-bit read of 0x0 back-to-back with prior word 0 → HRDATA=64'h0000_A500_0000_0000 with no stall (forwarding).
- WAIT_STATES=3, 32-bit read of 0x100 → HREADYOUT low for exactly 3 cycles, then high with correct data and HRESP=0.
- Write to BASE_ADDR + DEPTH*8, and a 32-bit access to 0x2 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
- HRESET asserted during WAIT of a write → the word keeps its old value; HREADYOUT=1 next cycle.
- AHB_MEM_MAILBOX_EN, byte write 8'hFF to 0xD058_0000 → one mailbox_wr pulse with mailbox_data=8'hFF. Without the macro, the same write → ERROR response.
